// File: rtl/mac_rx_frame.sv
// mac_rx_frame
// Receive-side Ethernet MAC framer. It removes preamble and SFD from the GMII
// byte stream, captures the 14-byte MAC header, and filters on the destination
// address. It forwards the payload without the trailing FCS and reports the
// FCS result with a one-cycle pulse at the end of each accepted frame.
module mac_rx_frame #(
    parameter logic [47:0] P_LOCAL_MAC    = 48'h00_0A_35_01_FE_C0,
    parameter bit          P_ACCEPT_BCAST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_gmii_rx_data,
    input  logic        i_gmii_rx_valid,
    output logic [7:0]  o_mac_data,
    output logic        o_mac_valid,
    output logic        o_mac_last,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [15:0] o_eth_type,
    output logic        o_crc_ok,
    output logic        o_rx_err
);

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam logic [3:0]  HDR_LAST      = 4'd13;
    localparam logic [2:0]  FILL_FULL     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_PAYLOAD,
        S_DROP
    } state_t;

    // Reflected CRC-32, one byte, LSB of the data byte first.
    function automatic logic [31:0] crc_update(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    state_t      state_q,     state_d;
    logic [31:0] crc_q,       crc_d;
    logic [3:0]  hdr_cnt_q,   hdr_cnt_d;
    logic [47:0] dst_sh_q,    dst_sh_d;
    logic [47:0] src_sh_q,    src_sh_d;
    logic [7:0]  type_hi_q,   type_hi_d;

    // Four-byte delay line holds the would-be FCS; the byte pushed out of it
    // waits in the pending register until the next byte proves it is payload.
    logic [3:0][7:0] dly_q,   dly_d;
    logic [7:0]  pend_q,      pend_d;
    logic [2:0]  fill_q,      fill_d;

    logic [7:0]  mac_data_q,  mac_data_d;
    logic        mac_valid_q, mac_valid_d;
    logic        mac_last_q,  mac_last_d;
    logic [47:0] dst_mac_q,   dst_mac_d;
    logic [47:0] src_mac_q,   src_mac_d;
    logic [15:0] eth_type_q,  eth_type_d;
    logic        crc_ok_q,    crc_ok_d;
    logic        rx_err_q,    rx_err_d;

    logic        addr_ok;

    // At header byte 13 the destination shadow already holds all six bytes.
    assign addr_ok = (dst_sh_q == P_LOCAL_MAC) ||
                     (P_ACCEPT_BCAST && (dst_sh_q == BCAST_MAC));

    // Next-state, shadow, delay-line and output computation for one input byte.
    always_comb begin
        // NOTE: every variable gets its hold/idle value first so that no path
        // through the case leaves one unassigned and infers a latch.
        state_d     = state_q;
        crc_d       = crc_q;
        hdr_cnt_d   = hdr_cnt_q;
        dst_sh_d    = dst_sh_q;
        src_sh_d    = src_sh_q;
        type_hi_d   = type_hi_q;
        dly_d       = dly_q;
        pend_d      = pend_q;
        fill_d      = fill_q;
        mac_data_d  = 8'h00;
        mac_valid_d = 1'b0;
        mac_last_d  = 1'b0;
        dst_mac_d   = dst_mac_q;
        src_mac_d   = src_mac_q;
        eth_type_d  = eth_type_q;
        crc_ok_d    = 1'b0;
        rx_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_gmii_rx_valid) begin
                    if (i_gmii_rx_data == PREAMBLE_BYTE) state_d = S_PREAMBLE;
                    else                                 state_d = S_DROP;
                end
            end

            S_PREAMBLE: begin
                if (!i_gmii_rx_valid) begin
                    state_d = S_IDLE;
                end else if (i_gmii_rx_data == SFD_BYTE) begin
                    state_d   = S_HEADER;
                    crc_d     = CRC_INIT;
                    hdr_cnt_d = 4'd0;
                end else if (i_gmii_rx_data != PREAMBLE_BYTE) begin
                    state_d = S_DROP;
                end
            end

            S_HEADER: begin
                if (!i_gmii_rx_valid) begin
                    state_d = S_IDLE;
                end else begin
                    crc_d     = crc_update(crc_q, i_gmii_rx_data);
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q < 4'd6)       dst_sh_d  = {dst_sh_q[39:0], i_gmii_rx_data};
                    else if (hdr_cnt_q < 4'd12) src_sh_d  = {src_sh_q[39:0], i_gmii_rx_data};
                    else                        type_hi_d = i_gmii_rx_data;

                    if (hdr_cnt_q == HDR_LAST) begin
                        if (addr_ok) begin
                            dst_mac_d  = dst_sh_q;
                            src_mac_d  = src_sh_q;
                            eth_type_d = {type_hi_q, i_gmii_rx_data};
                            fill_d     = 3'd0;
                            state_d    = S_PAYLOAD;
                        end else begin
                            state_d = S_DROP;
                        end
                    end
                end
            end

            S_PAYLOAD: begin
                if (i_gmii_rx_valid) begin
                    crc_d = crc_update(crc_q, i_gmii_rx_data);
                    if (fill_q == FILL_FULL) begin
                        mac_data_d  = pend_q;
                        mac_valid_d = 1'b1;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                    pend_d = dly_q[3];
                    dly_d  = {dly_q[2:0], i_gmii_rx_data};
                end else begin
                    if (fill_q == FILL_FULL) begin
                        mac_data_d  = pend_q;
                        mac_valid_d = 1'b1;
                        mac_last_d  = 1'b1;
                        crc_ok_d    = (crc_q == CRC_RESIDUE);
                        rx_err_d    = (crc_q != CRC_RESIDUE);
                    end else begin
                        // Frame ended inside what can only be FCS: runt.
                        rx_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end

            S_DROP: begin
                if (!i_gmii_rx_valid) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs; everything clears on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            crc_q       <= '0;
            hdr_cnt_q   <= '0;
            dst_sh_q    <= '0;
            src_sh_q    <= '0;
            type_hi_q   <= '0;
            dly_q       <= '0;
            pend_q      <= '0;
            fill_q      <= '0;
            mac_data_q  <= '0;
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
            dst_mac_q   <= '0;
            src_mac_q   <= '0;
            eth_type_q  <= '0;
            crc_ok_q    <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // values computed from the previous cycle, independent of order.
            state_q     <= state_d;
            crc_q       <= crc_d;
            hdr_cnt_q   <= hdr_cnt_d;
            dst_sh_q    <= dst_sh_d;
            src_sh_q    <= src_sh_d;
            type_hi_q   <= type_hi_d;
            dly_q       <= dly_d;
            pend_q      <= pend_d;
            fill_q      <= fill_d;
            mac_data_q  <= mac_data_d;
            mac_valid_q <= mac_valid_d;
            mac_last_q  <= mac_last_d;
            dst_mac_q   <= dst_mac_d;
            src_mac_q   <= src_mac_d;
            eth_type_q  <= eth_type_d;
            crc_ok_q    <= crc_ok_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign o_mac_data  = mac_data_q;
    assign o_mac_valid = mac_valid_q;
    assign o_mac_last  = mac_last_q;
    assign o_dst_mac   = dst_mac_q;
    assign o_src_mac   = src_mac_q;
    assign o_eth_type  = eth_type_q;
    assign o_crc_ok    = crc_ok_q;
    assign o_rx_err    = rx_err_q;

endmodule

// File: tb/tb_mac_rx_frame.sv
// Directed bench for mac_rx_frame: frames are built with a software FCS,
// driven on the falling edge, and the output stream is collected on the
// falling edge and compared with the expected payload.
module tb_mac_rx_frame;

    localparam logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0;
    localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  o_mac_data;
    logic        o_mac_valid;
    logic        o_mac_last;
    logic [47:0] o_dst_mac;
    logic [47:0] o_src_mac;
    logic [15:0] o_eth_type;
    logic        o_crc_ok;
    logic        o_rx_err;

    mac_rx_frame dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_gmii_rx_data  (rx_data),
        .i_gmii_rx_valid (rx_valid),
        .o_mac_data      (o_mac_data),
        .o_mac_valid     (o_mac_valid),
        .o_mac_last      (o_mac_last),
        .o_dst_mac       (o_dst_mac),
        .o_src_mac       (o_src_mac),
        .o_eth_type      (o_eth_type),
        .o_crc_ok        (o_crc_ok),
        .o_rx_err        (o_rx_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] tx_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         last_q[$];
    int ok_cnt = 0, err_cnt = 0, both_cnt = 0;
    int first_cyc = 0, ok_cyc = 0, drv_cyc = 0, low_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output collector.
    always @(negedge clk) begin
        if (o_mac_valid) begin
            if (rx_q.size() == 0) first_cyc = cyc;
            rx_q.push_back(o_mac_data);
            if (o_mac_last) last_q.push_back(rx_q.size() - 1);
        end
        if (o_crc_ok) begin
            ok_cnt++;
            ok_cyc = cyc;
        end
        if (o_rx_err) err_cnt++;
        if (o_crc_ok && o_rx_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    task automatic set_payload(input logic [7:0] base, input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(base + 8'(i));
    endtask

    // Builds preamble + SFD + header + pl_q + FCS into tx_q; flip corrupts
    // payload byte 10 after the FCS has been computed.
    task automatic make_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] typ, input bit flip);
        logic [7:0]  body[$];
        logic [31:0] crc;
        logic [31:0] fcs;
        body.delete();
        for (int i = 5; i >= 0; i--) body.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) body.push_back(src[i*8 +: 8]);
        body.push_back(typ[15:8]);
        body.push_back(typ[7:0]);
        foreach (pl_q[i]) body.push_back(pl_q[i]);
        crc = 32'hFFFF_FFFF;
        foreach (body[i]) crc = crc_byte(crc, body[i]);
        fcs = ~crc;
        for (int i = 0; i < 4; i++) body.push_back(fcs[i*8 +: 8]);
        if (flip) body[24] = body[24] ^ 8'h04;
        tx_q.delete();
        repeat (7) tx_q.push_back(8'h55);
        tx_q.push_back(8'hD5);
        foreach (body[i]) tx_q.push_back(body[i]);
    endtask

    task automatic send_tx();
        foreach (tx_q[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = tx_q[i];
            if (i == 22) drv_cyc = cyc;
        end
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        low_cyc  = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        rx_q.delete();
        last_q.delete();
        exp_q.delete();
        ok_cnt   = 0;
        err_cnt  = 0;
        both_cnt = 0;
    endtask

    task automatic check_rx(input string name, input int n_ok, input int n_err);
        check({name, " nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s byte%0d", name, i), rx_q[i], exp_q[i]);
        check({name, " crc_ok"}, ok_cnt, n_ok);
        check({name, " rx_err"}, err_cnt, n_err);
        check({name, " ok_and_err"}, both_cnt, 0);
    endtask

    task automatic check_zero(input string name);
        check({name, " mac_valid"}, o_mac_valid, 0);
        check({name, " mac_data"},  o_mac_data,  0);
        check({name, " mac_last"},  o_mac_last,  0);
        check({name, " crc_ok"},    o_crc_ok,    0);
        check({name, " rx_err"},    o_rx_err,    0);
        check({name, " dst_mac"},   o_dst_mac,   0);
        check({name, " src_mac"},   o_src_mac,   0);
        check({name, " eth_type"},  o_eth_type,  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_pre;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Good unicast frame.
        clear_mon();
        set_payload(8'h00, 46);
        make_frame(LOCAL_MAC, 48'h11_22_33_44_55_66, 16'h0800, 1'b0);
        exp_q = pl_q;
        send_tx();
        go_idle(10);
        check_rx("good", 1, 0);
        check("good last_count", last_q.size(), 1);
        if (last_q.size() > 0) check("good last_pos", last_q[0], 45);
        check("good byte_latency", first_cyc - drv_cyc, 6);
        check("good flag_latency", ok_cyc - low_cyc, 1);
        check("good eth_type", o_eth_type, 16'h0800);
        check("good src_mac", o_src_mac, 48'h11_22_33_44_55_66);
        check("good dst_mac", o_dst_mac, LOCAL_MAC);

        // One payload bit flipped.
        clear_mon();
        make_frame(LOCAL_MAC, 48'h11_22_33_44_55_66, 16'h0800, 1'b1);
        exp_q = pl_q;
        exp_q[10] = exp_q[10] ^ 8'h04;
        send_tx();
        go_idle(10);
        check_rx("badfcs", 0, 1);
        check("badfcs last_count", last_q.size(), 1);
        if (last_q.size() > 0) check("badfcs last_pos", last_q[0], 45);

        // Foreign destination is dropped silently.
        clear_mon();
        set_payload(8'h40, 46);
        make_frame(48'h02_00_00_00_00_09, 48'hAA_BB_CC_DD_EE_FF, 16'h0806, 1'b0);
        send_tx();
        go_idle(10);
        check_rx("filter", 0, 0);
        check("filter last_count", last_q.size(), 0);
        check("filter dst_mac", o_dst_mac, LOCAL_MAC);
        check("filter src_mac", o_src_mac, 48'h11_22_33_44_55_66);
        check("filter eth_type", o_eth_type, 16'h0800);

        // Broadcast is accepted.
        clear_mon();
        set_payload(8'h60, 46);
        make_frame(BCAST, 48'h0A_0B_0C_0D_0E_0F, 16'h0806, 1'b0);
        exp_q = pl_q;
        send_tx();
        go_idle(10);
        check_rx("bcast", 1, 0);
        check("bcast dst_mac", o_dst_mac, BCAST);
        check("bcast src_mac", o_src_mac, 48'h0A_0B_0C_0D_0E_0F);
        check("bcast eth_type", o_eth_type, 16'h0806);

        // Runt: header plus 3 bytes.
        clear_mon();
        set_payload(8'h70, 3);
        make_frame(LOCAL_MAC, 48'h01_02_03_04_05_06, 16'h88B5, 1'b0);
        repeat (4) void'(tx_q.pop_back());
        send_tx();
        go_idle(10);
        check_rx("runt", 0, 1);
        check("runt last_count", last_q.size(), 0);
        check("runt eth_type", o_eth_type, 16'h88B5);

        // Two good frames, one idle cycle between them.
        clear_mon();
        set_payload(8'h00, 46);
        make_frame(LOCAL_MAC, 48'h11_22_33_44_55_66, 16'h0800, 1'b0);
        exp_q = pl_q;
        send_tx();
        go_idle(1);
        set_payload(8'h80, 50);
        make_frame(LOCAL_MAC, 48'h22_22_22_22_22_22, 16'h0801, 1'b0);
        foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
        send_tx();
        go_idle(10);
        check_rx("b2b", 2, 0);
        check("b2b last_count", last_q.size(), 2);
        if (last_q.size() == 2) begin
            check("b2b last0_pos", last_q[0], 45);
            check("b2b last1_pos", last_q[1], 95);
        end
        check("b2b src_mac", o_src_mac, 48'h22_22_22_22_22_22);

        // Reset in the middle of the payload, released while valid is high.
        clear_mon();
        set_payload(8'h00, 46);
        make_frame(LOCAL_MAC, 48'h11_22_33_44_55_66, 16'h0800, 1'b0);
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = tx_q[i];
        end
        @(negedge clk);
        rst     = 1'b1;
        rx_data = tx_q[42];
        @(negedge clk);
        rx_data = tx_q[43];
        check_zero("in_reset");
        n_pre = rx_q.size();
        @(negedge clk);
        rst     = 1'b0;
        rx_data = tx_q[44];
        for (int i = 45; i < tx_q.size(); i++) begin
            @(negedge clk);
            rx_data = tx_q[i];
        end
        go_idle(10);
        check("after_reset nbytes", rx_q.size(), n_pre);
        check("after_reset crc_ok", ok_cnt, 0);
        check("after_reset rx_err", err_cnt, 0);
        check("after_reset dst_mac", o_dst_mac, 0);

        // Next good frame after the reset.
        clear_mon();
        set_payload(8'h30, 46);
        make_frame(LOCAL_MAC, 48'h66_55_44_33_22_11, 16'h86DD, 1'b0);
        exp_q = pl_q;
        send_tx();
        go_idle(10);
        check_rx("post_rst", 1, 0);
        check("post_rst src_mac", o_src_mac, 48'h66_55_44_33_22_11);
        check("post_rst eth_type", o_eth_type, 16'h86DD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
